or_mask_splitter: RTL and testbench
===================================

Name: or_mask_splitter

Overview:
- Inverse companion to the ALU's 32-bit bitwise OR. It takes a merged 32-bit mask (the OR of several one-hot words) and unpacks it back into its individual one-hot words.
- Emits one word per accepted transfer, in ascending bit order, over a valid/ready interface.
- Used by the CPU for register-list and interrupt-pending decoding, and as a sequential consumer of OR results.
- Reports the number of set bits when finished.

Parameters:
- WIDTH, 32: mask width in bits.
- IDX_W, 5: index width. Must equal ceil(log2(WIDTH)).

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  request to load data_in. Honoured only in IDLE.
- data_in  input  WIDTH  merged mask to unpack.
- busy  output  1  high in EMIT and DONE.
- out_valid  output  1  out_onehot, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the current word.
- out_onehot  output  WIDTH  lowest remaining set bit, as a one-hot word.
- out_index  output  IDX_W  bit position of out_onehot.
- out_last  output  1  current word is the final one of this mask.
- done  output  1  one-cycle pulse; the unpack is complete.
- bit_count  output  IDX_W+1  number of words transferred for the last mask. Held until the next start.

Behaviour:
- Reset: reset_n sampled low at a rising edge forces the following, regardless of state, including mid-EMIT:
  - state=IDLE, remaining mask=0, counter=0.
  - busy=0, out_valid=0, out_onehot=0, out_index=0, out_last=0, done=0, bit_count=0.
  - A partially emitted mask is discarded.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 with data_in!=0: latch mask, clear counter, go to EMIT.
  - start=1 with data_in==0: clear counter, go directly to DONE. No word is emitted.
  - start=0: stay in IDLE.
- EMIT:
  - out_valid=1 combinationally while in EMIT.
  - out_onehot = mask & (~mask+1), i.e. the lowest set bit.
  - out_index = position of that bit.
  - out_last = 1 when exactly one bit remains.
- Transfer: out_valid&&out_ready at a rising edge.
  - Clears that bit in the mask and increments the counter.
  - If it was the last bit: go to DONE. Otherwise stay in EMIT; the next word appears the following cycle.
- Throughput: one word per cycle with out_ready held high.
- Latency: start accepted at edge N -> first word valid during cycle N+1.
- Backpressure: while out_valid=1 and out_ready=0, every output holds stable and the mask does not change.
- DONE: lasts exactly one cycle.
  - done=1, bit_count=counter (registered into bit_count on entry), busy=1.
  - Then go to IDLE.
- start is ignored outside IDLE. No queuing, no error; data_in is not sampled.
- Counter width IDX_W+1 prevents wrap: a full mask gives 32 (6'b100000).
- out_onehot is always zero or one-hot. The OR of all transferred words equals the latched data_in.

Test Plan:
- Reset, then start with data_in=32'h0000_0029, out_ready=1 -> cycles N+1..N+3 emit 32'h1 (idx 0), 32'h8 (idx 3), 32'h20 (idx 5, out_last=1). done pulses at N+4, bit_count=3, busy drops at N+5.
- data_in=32'hFFFF_FFFF, out_ready=1 -> 32 consecutive words with idx 0..31, out_last only on idx 31, done with bit_count=32.
- data_in=32'h8000_0001 with out_ready=0 for 3 cycles, then 1 -> 32'h1/idx 0 holds stable 3 cycles; then 32'h8000_0000/idx 31 with out_last=1; bit_count=2.
- data_in=0 -> no out_valid; done pulses the cycle after start, bit_count=0.
- During EMIT of 32'h0000_00F0, pulse start with data_in=32'h1 -> ignored; sequence 0x10, 0x20, 0x40, 0x80, bit_count=4.
- reset_n low after the second word of 32'h0000_0F00 -> next cycle IDLE, out_valid=0, bit_count=0. A new start with 32'h4 then emits a single word, idx 2.

Source files
------------

// File: rtl/or_mask_splitter.sv
// or_mask_splitter: unpacks a merged OR mask into its one-hot words, lowest bit first.
// Ports:
//   clock, reset_n    rising-edge clock, synchronous active-low reset
//   start, data_in    load request (IDLE only) and the mask to unpack
//   busy              high while emitting or finishing
//   out_valid/ready   valid/ready handshake for the emitted words
//   out_onehot        lowest remaining set bit as a one-hot word
//   out_index         bit position of out_onehot
//   out_last          current word is the final one
//   done              one-cycle completion pulse
//   bit_count         words transferred for the last mask
module or_mask_splitter #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_onehot,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             done,
   output logic [IDX_W:0]   bit_count
);
   typedef enum logic [1:0] {IDLE, EMIT, DONE} stateT;
   stateT state, stateNext;
   logic [WIDTH-1:0] mask, lowBit;
   logic [IDX_W:0] counter, bitCountReg;
   logic xfer, lastBit;
   assign lowBit = mask & (~mask + 1'b1);
   // clearing the lowest bit leaves nothing exactly when one bit remains
   assign lastBit = (mask & (mask - 1'b1)) == '0;
   assign out_valid = state == EMIT;
   assign out_onehot = out_valid ? lowBit : '0;
   assign out_last = out_valid && lastBit;
   assign busy = state != IDLE;
   assign done = state == DONE;
   assign bit_count = bitCountReg;
   assign xfer = out_valid && out_ready;
   always_comb begin
      out_index = '0;
      for (int i = 0; i < WIDTH; i++)
         if (out_onehot[i]) out_index = IDX_W'(i);
   end
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (start) stateNext = (data_in != '0) ? EMIT : DONE;
         EMIT: if (xfer && lastBit) stateNext = DONE;
         default: stateNext = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
         mask <= '0;
         counter <= '0;
         bitCountReg <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE && start) begin
            mask <= data_in;
            counter <= '0;
            if (data_in == '0) bitCountReg <= '0;
         end
         if (xfer) begin
            mask <= mask & ~lowBit;
            counter <= counter + 1'b1;
            // bit_count must already hold the final total during the DONE cycle
            if (lastBit) bitCountReg <= counter + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_or_mask_splitter.sv
// tb_or_mask_splitter: randomized and directed check of or_mask_splitter against a queue model.
module tb_or_mask_splitter;
   logic clock = 0, reset_n = 0, start = 0, out_ready = 0;
   logic [31:0] data_in = '0;
   logic busy, out_valid, out_last, done;
   logic [31:0] out_onehot;
   logic [4:0] out_index;
   logic [5:0] bit_count;
   int vectors = 0, miscompares = 0;
   int q[$];
   bit doneP = 0;
   int bc = 0, sent = 0;

   or_mask_splitter dut (
      .clock(clock), .reset_n(reset_n), .start(start), .data_in(data_in),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_onehot(out_onehot), .out_index(out_index), .out_last(out_last),
      .done(done), .bit_count(bit_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: queue of bit indices still to be emitted, plus a pending done pulse
   always @(posedge clock) begin
      if (!reset_n) begin
         q.delete();
         doneP = 0;
         bc = 0;
         sent = 0;
      end else if (doneP) doneP = 0;
      else if (q.size() > 0) begin
         if (out_ready) begin
            void'(q.pop_front());
            sent++;
            if (q.size() == 0) begin
               doneP = 1;
               bc = sent;
            end
         end
      end else if (start) begin
         for (int i = 0; i < 32; i++) if (data_in[i]) q.push_back(i);
         sent = 0;
         if (q.size() == 0) begin
            doneP = 1;
            bc = 0;
         end
      end
   end

   always @(negedge clock) begin
      bit v;
      v = q.size() > 0;
      check("out_valid", 64'(out_valid), 64'(v));
      check("out_onehot", 64'(out_onehot), v ? 64'(32'd1 << q[0]) : 64'd0);
      check("out_index", 64'(out_index), v ? 64'(q[0]) : 64'd0);
      check("out_last", 64'(out_last), 64'(q.size() == 1));
      check("done", 64'(done), 64'(doneP));
      check("busy", 64'(busy), 64'(v || doneP));
      check("bit_count", 64'(bit_count), 64'(bc));
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [31:0] d);
      start = 1;
      data_in = d;
      step();
      start = 0;
   endtask

   initial begin
      int budget;
      step();
      step();
      reset_n = 1;
      out_ready = 1;
      check("rst_busy", 64'(busy), 0);
      check("rst_bit_count", 64'(bit_count), 0);
      // 0x29 -> 0x1, 0x8, 0x20
      load(32'h29);
      check("t1_w0", 64'(out_onehot), 64'h1);
      check("t1_i0", 64'(out_index), 0);
      step();
      check("t1_w1", 64'(out_onehot), 64'h8);
      check("t1_i1", 64'(out_index), 3);
      step();
      check("t1_w2", 64'(out_onehot), 64'h20);
      check("t1_i2", 64'(out_index), 5);
      check("t1_last", 64'(out_last), 1);
      step();
      check("t1_done", 64'(done), 1);
      check("t1_cnt", 64'(bit_count), 3);
      step();
      check("t1_idle", 64'(busy), 0);
      // full mask
      load(32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         check("t2_idx", 64'(out_index), 64'(i));
         check("t2_last", 64'(out_last), 64'(i == 31));
         step();
      end
      check("t2_done", 64'(done), 1);
      check("t2_cnt", 64'(bit_count), 32);
      step();
      // backpressure
      out_ready = 0;
      load(32'h8000_0001);
      repeat (3) begin
         check("t3_hold", 64'(out_onehot), 64'h1);
         step();
      end
      out_ready = 1;
      check("t3_w0", 64'(out_onehot), 64'h1);
      step();
      check("t3_w1", 64'(out_onehot), 64'h8000_0000);
      check("t3_i1", 64'(out_index), 31);
      check("t3_last", 64'(out_last), 1);
      step();
      check("t3_cnt", 64'(bit_count), 2);
      step();
      // zero mask
      load(32'h0);
      check("t4_valid", 64'(out_valid), 0);
      check("t4_done", 64'(done), 1);
      check("t4_cnt", 64'(bit_count), 0);
      step();
      check("t4_idle", 64'(busy), 0);
      // start ignored while emitting
      load(32'hF0);
      check("t5_w0", 64'(out_onehot), 64'h10);
      step();
      start = 1;
      data_in = 32'h1;
      check("t5_w1", 64'(out_onehot), 64'h20);
      step();
      start = 0;
      check("t5_w2", 64'(out_onehot), 64'h40);
      step();
      check("t5_w3", 64'(out_onehot), 64'h80);
      step();
      check("t5_cnt", 64'(bit_count), 4);
      step();
      step();
      check("t5_noqueue", 64'(busy), 0);
      // reset mid-emit
      load(32'hF00);
      step();
      step();
      reset_n = 0;
      step();
      reset_n = 1;
      check("t6_valid", 64'(out_valid), 0);
      check("t6_busy", 64'(busy), 0);
      check("t6_cnt", 64'(bit_count), 0);
      load(32'h4);
      check("t6_idx", 64'(out_index), 2);
      check("t6_last", 64'(out_last), 1);
      step();
      check("t6_done_cnt", 64'(bit_count), 1);
      step();
      // random traffic
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 4))
            0: data_in = '0;
            1: data_in = 32'd1 << $urandom_range(0, 31);
            2: data_in = $urandom;
            default: data_in = $urandom & $urandom & $urandom;
         endcase
         start = 1;
         step();
         start = 0;
         budget = 0;
         while ((q.size() > 0 || doneP) && budget < 300) begin
            out_ready = $urandom_range(0, 3) != 0;
            start = $urandom_range(0, 7) == 0;
            data_in = $urandom;
            reset_n = $urandom_range(0, 199) != 0;
            step();
            budget++;
         end
         start = 0;
         reset_n = 1;
         if (budget >= 300) check("rand_timeout", 64'(budget), 0);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
